// File: rtl/addr8s_selfcheck.sv
// Exhaustive 8-bit signed adder self-check sequencer: sweeps all {A,B} pairs and compares s_i to a golden sum.
// Optional build macro ADDR8S_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module addr8s_selfcheck #(
    parameter int PIPE = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic [7:0]  a_o,
    output logic [7:0]  b_o,
    input  logic [8:0]  s_i,
    output logic        busy,
    output logic        done,
    output logic [16:0] mismatch_cnt,
    output logic        first_fail_vld,
    output logic [15:0] first_fail_vec
);

    // state | meaning
    // IDLE  | waiting for start after reset
    // RUN   | launching one vector per cycle, comparing delayed results
    // DRAIN | all vectors launched, waiting for the delay line to empty
    // DONE  | sweep finished or aborted, results held until next start
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [15:0]        v_q, v_d;
    logic [16:0]        cnt_q, cnt_d;
    logic               ffv_q, ffv_d;
    logic [15:0]        ffvec_q, ffvec_d;
    logic [PIPE:0]      vld_q, vld_d;
    logic [PIPE:0][8:0] gold_q, gold_d;
    logic [PIPE:0][15:0] vec_q, vec_d;
    logic               active;
    logic               cmp;
    logic               miss;

    function automatic logic [8:0] golden(input logic [15:0] v);
        return {v[15], v[15:8]} + {v[7], v[7:0]};
    endfunction

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        ffv_d   = ffv_q;
        ffvec_d = ffvec_q;
        for (int i = 1; i <= PIPE; i++) begin
            vld_d[i]  = vld_q[i-1];
            gold_d[i] = gold_q[i-1];
            vec_d[i]  = vec_q[i-1];
        end
        vld_d[0]  = 1'b0;
        gold_d[0] = gold_q[0];
        vec_d[0]  = vec_q[0];

        active = (state_q == RUN) || (state_q == DRAIN);
        cmp    = active && !abort && vld_q[PIPE];
        miss   = cmp && (s_i != gold_q[PIPE]);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    v_d       = 16'h0000;
                    cnt_d     = '0;
                    ffv_d     = 1'b0;
                    ffvec_d   = '0;
                    vld_d[0]  = 1'b1;
                    gold_d[0] = golden(16'h0000);
                    vec_d[0]  = 16'h0000;
                end
            end
            RUN: begin
                if (v_q != 16'hFFFF) begin
                    v_d       = v_q + 16'd1;
                    vld_d[0]  = 1'b1;
                    gold_d[0] = golden(v_q + 16'd1);
                    vec_d[0]  = v_q + 16'd1;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: ;
        endcase

        if (miss) begin
            cnt_d = cnt_q + 17'd1;
            if (!ffv_q) begin
                ffv_d   = 1'b1;
                ffvec_d = vec_q[PIPE];
            end
        end

        // The last vector's compare closes the sweep, even with PIPE=0 where it lands while still in RUN
        if (cmp && vec_q[PIPE] == 16'hFFFF)
            state_d = DONE;
`ifdef ADDR8S_STOP_ON_FAIL_EN
        if (miss)
            state_d = DONE;
`endif
        if (active && abort)
            state_d = DONE;

        if (active && state_d == DONE)
            vld_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            v_q     <= '0;
            cnt_q   <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
            vld_q   <= '0;
            gold_q  <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            ffv_q   <= ffv_d;
            ffvec_q <= ffvec_d;
            vld_q   <= vld_d;
            gold_q  <= gold_d;
            vec_q   <= vec_d;
        end
    end

    assign a_o            = v_q[15:8];
    assign b_o            = v_q[7:0];
    assign busy           = (state_q == RUN) || (state_q == DRAIN);
    assign done           = (state_q == DONE);
    assign mismatch_cnt   = cnt_q;
    assign first_fail_vld = ffv_q;
    assign first_fail_vec = ffvec_q;

endmodule

// File: tb/tb_addr8s_selfcheck.sv
// Directed bench: a PIPE=0 instance with selectable adder faults and a PIPE=2 instance with s_i[0] stuck-at-0.
module tb_addr8s_selfcheck;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0, abort0 = 1'b0, start2 = 1'b0, abort2 = 1'b0;
    logic [7:0]  a0, b0, a2, b2;
    logic [8:0]  s0, s2;
    logic        busy0, done0, vld0, busy2, done2, vld2;
    logic [16:0] cnt0, cnt2;
    logic [15:0] vec0, vec2;
    int          f0 = 0;
    logic [15:0] p1 = '0, p2 = '0;
    int          n_chk = 0, n_pass = 0;
    int          at0, at2;
    logic        got0, got2;

    always #5 clk = ~clk;

    addr8s_selfcheck #(.PIPE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .a_o(a0), .b_o(b0), .s_i(s0), .busy(busy0), .done(done0),
        .mismatch_cnt(cnt0), .first_fail_vld(vld0), .first_fail_vec(vec0));

    addr8s_selfcheck #(.PIPE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .a_o(a2), .b_o(b2), .s_i(s2), .busy(busy2), .done(done2),
        .mismatch_cnt(cnt2), .first_fail_vld(vld2), .first_fail_vec(vec2));

    function automatic logic [8:0] add9(input logic [7:0] a, input logic [7:0] b);
        return {a[7], a} + {b[7], b};
    endfunction

    // Adder models: f0 = 0 ideal, 1 = bit0 stuck-at-0, 2 = bit8 stuck-at-1
    always_comb begin
        s0 = add9(a0, b0);
        if (f0 == 1) s0[0] = 1'b0;
        if (f0 == 2) s0[8] = 1'b1;
    end

    always @(posedge clk) begin
        p1 <= {a2, b2};
        p2 <= p1;
    end
    assign s2 = add9(p2[15:8], p2[7:0]) & 9'h1FE;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

`ifdef ADDR8S_STOP_ON_FAIL_EN
    localparam int EXP_AT0 = 1, EXP_AT2 = 4;
    localparam int EXP_CNT0 = 1, EXP_CNT2 = 1;
`else
    localparam int EXP_AT0 = 65536, EXP_AT2 = 65538;
    localparam int EXP_CNT0 = 32640, EXP_CNT2 = 32768;
`endif

    initial begin
        tick();
        tick();
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_cnt", cnt0, 0);
        chk("rst_vld", vld0, 0);
        chk("rst_vec", vec0, 0);
        chk("rst_ab", {a0, b0}, 0);
        chk("rst_busy2", busy2, 0);
        rst_n = 1'b1;
        tick();
        abort0 = 1'b1;
        tick();
        abort0 = 1'b0;
        chk("idle_abort_ignored", {busy0, done0}, 0);

        // Sweep with s_i[0] stuck-at-0: abort, or early stop when the macro is set
        f0 = 1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("start_busy", busy0, 1);
        chk("start_ab", {a0, b0}, 0);
`ifdef ADDR8S_STOP_ON_FAIL_EN
        tick();
        chk("sof_not_done_t1", done0, 0);
        tick();
        chk("sof_done_t2", done0, 1);
        chk("sof_cnt", cnt0, 1);
        chk("sof_vec", vec0, 16'h0001);
        chk("sof_busy", busy0, 0);
`else
        repeat (100) tick();
        chk("pre_abort_busy", busy0, 1);
        abort0 = 1'b1;
        tick();
        abort0 = 1'b0;
        chk("abort_done", done0, 1);
        chk("abort_busy", busy0, 0);
        chk("abort_cnt", cnt0, 50);
        chk("abort_ffvld", vld0, 1);
        chk("abort_ffvec", vec0, 16'h0001);
        tick();
        chk("abort_frozen", cnt0, 50);
`endif

        // Restart with an ideal adder and start held high throughout
        f0 = 0;
        start0 = 1'b1;
        tick();
        chk("restart_busy", busy0, 1);
        chk("restart_done", done0, 0);
        chk("restart_cnt", cnt0, 0);
        chk("restart_vld", vld0, 0);
        chk("restart_vec", vec0, 0);
        chk("restart_ab", {a0, b0}, 0);
        for (int k = 1; k < 1000; k++) begin
            tick();
            chk("held_start_v", {a0, b0}, k);
        end
        chk("ideal_cnt", cnt0, 0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy0, 0);
        chk("midrst_done", done0, 0);
        chk("midrst_ab", {a0, b0}, 0);
        chk("midrst_vld", vld0, 0);
        start0 = 1'b0;
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_idle", {busy0, done0}, 0);

        // Full sweeps: dut0 with s_i[8] stuck-at-1, dut2 (PIPE=2) with s_i[0] stuck-at-0
        f0 = 2;
        start0 = 1'b1;
        start2 = 1'b1;
        tick();
        start0 = 1'b0;
        start2 = 1'b0;
        got0 = 1'b0;
        got2 = 1'b0;
        at0 = -1;
        at2 = -1;
        for (int n = 1; n <= 65600 && !(got0 && got2); n++) begin
            tick();
            if (!got0 && done0) begin got0 = 1'b1; at0 = n; end
            if (!got2 && done2) begin got2 = 1'b1; at2 = n; end
        end
        chk("sweep0_done_edge", at0, EXP_AT0);
        chk("sweep2_done_edge", at2, EXP_AT2);
        chk("sweep0_cnt", cnt0, EXP_CNT0);
        chk("sweep0_ffvld", vld0, 1);
        chk("sweep0_ffvec", vec0, 16'h0000);
        chk("sweep0_busy", busy0, 0);
        chk("sweep2_cnt", cnt2, EXP_CNT2);
        chk("sweep2_ffvld", vld2, 1);
        chk("sweep2_ffvec", vec2, 16'h0001);
        chk("sweep2_busy", busy2, 0);
        tick();
        chk("sweep0_done_held", done0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
